// File: rtl/mac_requant_q7.sv
// rtl/mac_requant_q7.sv - Accumulates Q1.15 product groups plus a Q1.7 bias and requantises to Q1.7
// Round half toward +inf, saturate, optional ReLU; one registered result with valid/ready.
module mac_requant_q7 #(
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 8,
    parameter int ACCW   = 24,
    parameter int RELU   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IWIDTH-1:0] in_data,
    input  logic [OWIDTH-1:0] in_bias,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OWIDTH-1:0] out_data,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int SH = IWIDTH - OWIDTH;
    localparam logic signed [ACCW-1:0] HALF = ACCW'(1) <<< (SH - 1);
    localparam logic signed [ACCW-1:0] MAXV = ACCW'((1 << (OWIDTH - 1)) - 1);
    localparam logic signed [ACCW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_OUT = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic signed [ACCW-1:0]   acc_q, acc_d;
    logic [OWIDTH-1:0]        out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;
    logic signed [ACCW-1:0]   term, bias_ext, bias_term, sum, rnd, r;
    logic [OWIDTH-1:0]        q_val;
    logic                     sat;
    logic                     accept;

    assign in_ready  = (state_q != S_OUT) || out_ready;
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign accept    = in_valid && in_ready;

    // Any beat outside an open group starts a new one, so the bias seeds the sum there.
    always_comb begin
        term      = {{(ACCW-IWIDTH){in_data[IWIDTH-1]}}, in_data};
        bias_ext  = {{(ACCW-OWIDTH){in_bias[OWIDTH-1]}}, in_bias};
        bias_term = bias_ext <<< SH;
        sum       = ((state_q == S_ACC) ? acc_q : bias_term) + term;
        rnd       = sum + HALF;
        r         = rnd >>> SH;
        sat       = 1'b0;
        if (r > MAXV) begin
            q_val = MAXV[OWIDTH-1:0];
            sat   = 1'b1;
        end else if (r < MINV) begin
            q_val = MINV[OWIDTH-1:0];
            sat   = 1'b1;
        end else begin
            q_val = r[OWIDTH-1:0];
        end
        if (RELU != 0 && q_val[OWIDTH-1]) begin
            q_val = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (state_q == S_OUT && out_ready && !in_valid) begin
            state_d = S_IDLE;
        end
        if (accept) begin
            if (in_last) begin
                out_data_d = q_val;
                out_sat_d  = sat;
                acc_d      = '0;
                state_d    = S_OUT;
            end else begin
                acc_d   = sum;
                state_d = S_ACC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end
endmodule

// File: tb/tb_mac_requant_q7.sv
// tb/tb_mac_requant_q7.sv - Self-checking bench for mac_requant_q7 (RELU 0 and RELU 1 instances)
module tb_mac_requant_q7;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic [7:0]  in_bias;
    logic        in_last, in_valid, out_ready;
    logic        ready0, ready1, valid0, valid1, sat0, sat1;
    logic [7:0]  data0, data1;

    always #5 clk = ~clk;

    mac_requant_q7 #(.RELU(0)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_bias(in_bias), .in_last(in_last),
        .in_valid(in_valid), .in_ready(ready0), .out_data(data0), .out_sat(sat0),
        .out_valid(valid0), .out_ready(out_ready));
    mac_requant_q7 #(.RELU(1)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_bias(in_bias), .in_last(in_last),
        .in_valid(in_valid), .in_ready(ready1), .out_data(data1), .out_sat(sat1),
        .out_valid(valid1), .out_ready(out_ready));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfers = 0;
    bit mon_en = 0;
    bit rand_rdy = 0;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic [7:0] dr;
        int         cyc;
        bit         seen;
    } exp_t;
    exp_t exp_q[$];
    int   g_terms[$];
    int   g_bias;
    bit   g_open = 0;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  b;
        logic [7:0]  ed;
        logic        es;
    } vec_t;
    vec_t tbl[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int floor256(input int x);
        return (x >= 0) ? x / 256 : -((-x + 255) / 256);
    endfunction

    function automatic void requant(input int total, input bit relu,
                                    output logic [7:0] d, output logic s);
        int r;
        r = floor256(total + 128);
        s = 1'b0;
        if (r > 127) begin r = 127; s = 1'b1; end
        else if (r < -128) begin r = -128; s = 1'b1; end
        if (relu && r < 0) r = 0;
        d = r[7:0];
    endfunction

    // Reference model: observe handshakes at the falling edge, score results as they appear.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready_rule", ready0, (!valid0 || out_ready) ? 1 : 0);
            chk("relu_inst_valid", valid1, valid0);
            if (valid0) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    chk("data", data0, exp_q[0].d);
                    chk("sat", sat0, exp_q[0].s);
                    chk("relu_data", data1, exp_q[0].dr);
                    chk("relu_sat", sat1, exp_q[0].s);
                    if (!exp_q[0].seen) begin
                        chk("latency", cyc, exp_q[0].cyc);
                        exp_q[0].seen = 1;
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        xfers++;
                    end
                end
            end
            if (in_valid && ready0 && !rst) begin
                if (!g_open) begin
                    g_bias = $signed(in_bias);
                    g_terms.delete();
                    g_open = 1;
                end
                g_terms.push_back($signed(in_data));
                if (in_last) begin
                    exp_t e;
                    int total;
                    total = g_bias * 256;
                    foreach (g_terms[i]) total += g_terms[i];
                    requant(total, 0, e.d, e.s);
                    requant(total, 1, e.dr, e.s);
                    e.cyc  = cyc + 1;
                    e.seen = 0;
                    exp_q.push_back(e);
                    g_open = 0;
                end
            end
            if (rst) begin
                exp_q.delete();
                g_open = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic [7:0] b, input logic l);
        in_data = d; in_bias = b; in_last = l; in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ready0) begin
                step();
                return;
            end
            step();
        end
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 16'hxxxx;
        in_bias  = 8'hxx;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int c0, x0, n;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_bias = '0;
        out_ready = 1'b0;
        step();
        @(negedge clk);
        chk("rst_valid", valid0, 0);
        chk("rst_data", data0, 0);
        chk("rst_sat", sat0, 0);
        chk("rst_in_ready", ready0, 1);
        step();
        rst = 1'b0; out_ready = 1'b1; mon_en = 1;

        tbl[0] = '{16'h0080, 8'h00, 8'h01, 1'b0};
        tbl[1] = '{16'h007F, 8'h00, 8'h00, 1'b0};
        tbl[2] = '{16'hFF80, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{16'hFF7F, 8'h00, 8'hFF, 1'b0};
        tbl[4] = '{16'h2000, 8'h10, 8'h30, 1'b0};
        foreach (tbl[i]) begin
            beat(tbl[i].d, tbl[i].b, 1'b1);
            idle();
            @(negedge clk);
            chk("tbl_valid", valid0, 1);
            chk("tbl_data", data0, tbl[i].ed);
            chk("tbl_sat", sat0, tbl[i].es);
            step();
        end

        beat(16'h4000, 8'h00, 1'b0); beat(16'h4000, 8'h00, 1'b0); beat(16'h4000, 8'h00, 1'b1);
        idle();
        @(negedge clk);
        chk("sat_pos_data", data0, 8'h7F);
        chk("sat_pos_flag", sat0, 1);
        step();
        beat(16'h8000, 8'h00, 1'b0); beat(16'h8000, 8'h00, 1'b0); beat(16'h8000, 8'h00, 1'b1);
        idle();
        @(negedge clk);
        chk("sat_neg_data", data0, 8'h80);
        chk("sat_neg_flag", sat0, 1);
        chk("relu_neg_data", data1, 8'h00);
        chk("relu_neg_flag", sat1, 1);
        step();

        out_ready = 1'b0;
        beat(16'h1000, 8'h00, 1'b0); beat(16'h1000, 8'h00, 1'b1);
        in_data = 16'h0080; in_bias = 8'h00; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", valid0, 1);
            chk("bp_data", data0, 8'h20);
            chk("bp_in_ready", ready0, 0);
            step();
        end
        out_ready = 1'b1;
        x0 = xfers;
        c0 = cyc;
        for (int i = 0; i < 8; i++) beat(16'(i * 256), 8'(i), 1'b1);
        chk("stream_cycles", cyc - c0, 8);
        idle();
        step(); step();
        chk("stream_results", xfers - x0, 9);

        beat(16'h0100, 8'h02, 1'b0); beat(16'h0100, 8'h55, 1'b0);
        beat(16'h0100, 8'h80, 1'b0); beat(16'h0100, 8'h7F, 1'b1);
        idle();
        @(negedge clk);
        chk("bias_first_only", data0, 8'h06);
        step();

        beat(16'h4000, 8'h00, 1'b0); beat(16'h4000, 8'h00, 1'b0);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", valid0, 0);
        chk("midrst_data", data0, 0);
        chk("midrst_sat", sat0, 0);
        chk("midrst_in_ready", ready0, 1);
        step();
        beat(16'h0100, 8'h00, 1'b1);
        idle();
        @(negedge clk);
        chk("post_rst_data", data0, 8'h01);
        step();

        rand_rdy = 1;
        for (int g = 0; g < 40; g++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                logic [15:0] d;
                d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0800) - 16'h0400);
                beat(d, 8'($urandom), (k == n - 1) ? 1'b1 : 1'b0);
                if ($urandom_range(0, 4) == 0) begin
                    idle();
                    step();
                end
            end
        end
        idle();
        rand_rdy = 0;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        chk("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
